// File: rtl/letter_entry_buffer.sv
// Ten-slot letter entry buffer feeding the letter/underline drawing datapath.
// Accepts keyboard codes, keeps one pending key during redraws, locks on Enter.
module letter_entry_buffer #(
   parameter logic [7:0] BLANK      = 8'h20,
   parameter logic [7:0] ENTER_CODE = 8'h0D,
   parameter logic [7:0] BS_CODE    = 8'h08
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic [7:0] key_code,
   input  logic       key_valid,
   input  logic       draw_done,
   output logic [7:0] first_letter,
   output logic [7:0] second_letter,
   output logic [7:0] third_letter,
   output logic [7:0] fourth_letter,
   output logic [7:0] fifth_letter,
   output logic [7:0] sixth_letter,
   output logic [7:0] seventh_letter,
   output logic [7:0] eighth_letter,
   output logic [7:0] ninth_letter,
   output logic [7:0] tenth_letter,
   output logic [3:0] letterNum,
   output logic       draw_restart,
   output logic       draw_enable,
   output logic       busy,
   output logic       word_ready,
   output logic       key_dropped
);

   typedef enum logic [1:0] {IDLE, INIT, DRAW, LOCKED} state_t;

   state_t     state;
   logic [7:0] slot [10];
   logic [3:0] num;
   logic       pend_valid;
   logic [7:0] pend_code;

   logic       key_avail;
   logic [7:0] code;
   logic       is_upper;
   logic       is_lower;
   logic       is_letter;
   logic [7:0] up_code;

   // Pending key always wins over a fresh strobe so key order is kept.
   assign key_avail = pend_valid | key_valid;
   assign code      = pend_valid ? pend_code : key_code;
   assign is_upper  = (code >= 8'h41) && (code <= 8'h5A);
   assign is_lower  = (code >= 8'h61) && (code <= 8'h7A);
   assign is_letter = is_upper | is_lower;
   assign up_code   = is_lower ? (code - 8'h20) : code;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         num         <= 4'd0;
         word_ready  <= 1'b0;
         key_dropped <= 1'b0;
         pend_valid  <= 1'b0;
         pend_code   <= 8'h00;
         for (int i = 0; i < 10; i++) slot[i] <= BLANK;
      end else if (clear) begin
         state       <= INIT;
         num         <= 4'd0;
         word_ready  <= 1'b0;
         key_dropped <= 1'b0;
         pend_valid  <= 1'b0;
         for (int i = 0; i < 10; i++) slot[i] <= BLANK;
      end else begin
         unique case (state)
            IDLE: begin
               if (pend_valid) begin
                  pend_valid <= key_valid;
                  pend_code  <= key_code;
               end
               if (key_avail) begin
                  unique case (1'b1)
                     is_letter: begin
                        if (num != 4'd10) begin
                           for (int i = 0; i < 10; i++)
                              if (num == 4'(i)) slot[i] <= up_code;
                           num   <= num + 4'd1;
                           state <= INIT;
                        end
                     end
                     (code == BS_CODE): begin
                        if (num != 4'd0) begin
                           for (int i = 0; i < 10; i++)
                              if (num - 4'd1 == 4'(i)) slot[i] <= BLANK;
                           num   <= num - 4'd1;
                           state <= INIT;
                        end
                     end
                     (code == ENTER_CODE): begin
                        if (num != 4'd0) begin
                           word_ready <= 1'b1;
                           pend_valid <= 1'b0;
                           state      <= LOCKED;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            INIT, DRAW: begin
               if (state == INIT) state <= DRAW;
               else if (draw_done) state <= IDLE;
               if (key_valid) begin
                  if (!pend_valid) begin
                     pend_valid <= 1'b1;
                     pend_code  <= key_code;
                  end else begin
                     key_dropped <= 1'b1;
                  end
               end
            end
            LOCKED: ;
            default: state <= IDLE;
         endcase
      end
   end

   assign draw_restart = (state == INIT);
   assign draw_enable  = (state == DRAW);
   assign busy         = (state == INIT) || (state == DRAW);
   assign letterNum    = num;

   assign first_letter   = slot[0];
   assign second_letter  = slot[1];
   assign third_letter   = slot[2];
   assign fourth_letter  = slot[3];
   assign fifth_letter   = slot[4];
   assign sixth_letter   = slot[5];
   assign seventh_letter = slot[6];
   assign eighth_letter  = slot[7];
   assign ninth_letter   = slot[8];
   assign tenth_letter   = slot[9];

endmodule

// File: tb/tb_letter_entry_buffer.sv
// Directed bench for letter_entry_buffer: entry, full buffer, pending key,
// clear, Enter lock and asynchronous reset during a draw.
module tb_letter_entry_buffer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic       key_valid = 1'b0;
   logic       draw_done = 1'b0;
   logic [7:0] l0, l1, l2, l3, l4, l5, l6, l7, l8, l9;
   logic [3:0] letterNum;
   logic       draw_restart, draw_enable, busy, word_ready, key_dropped;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   letter_entry_buffer dut (
      .clock(clock), .reset(reset), .clear(clear),
      .key_code(key_code), .key_valid(key_valid), .draw_done(draw_done),
      .first_letter(l0), .second_letter(l1), .third_letter(l2),
      .fourth_letter(l3), .fifth_letter(l4), .sixth_letter(l5),
      .seventh_letter(l6), .eighth_letter(l7), .ninth_letter(l8),
      .tenth_letter(l9), .letterNum(letterNum),
      .draw_restart(draw_restart), .draw_enable(draw_enable),
      .busy(busy), .word_ready(word_ready), .key_dropped(key_dropped)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Key is sampled on the posedge between the two falling edges.
   task automatic press(input logic [7:0] c);
      @(negedge clock);
      key_code  = c;
      key_valid = 1'b1;
      @(negedge clock);
      key_valid = 1'b0;
   endtask

   task automatic finish_draw();
      @(negedge clock);
      draw_done = 1'b1;
      @(negedge clock);
      draw_done = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_num", 32'(letterNum), 0);
      chk("rst_l0", 32'(l0), 32'h20);
      chk("rst_l9", 32'(l9), 32'h20);
      chk("rst_busy", 32'({draw_restart, draw_enable, busy}), 0);
      chk("rst_flags", 32'({word_ready, key_dropped}), 0);
      @(negedge clock);
      reset = 1'b0;

      press(8'h61);
      chk("a_l0", 32'(l0), 32'h41);
      chk("a_num", 32'(letterNum), 1);
      chk("a_restart", 32'({draw_restart, draw_enable}), 32'b10);
      @(negedge clock);
      chk("a_enable", 32'({draw_restart, draw_enable, busy}), 32'b011);
      repeat (3) @(negedge clock);
      chk("a_hold", 32'(draw_enable), 1);
      draw_done = 1'b1;
      @(negedge clock);
      draw_done = 1'b0;
      chk("a_done", 32'({draw_enable, busy}), 0);

      for (int i = 1; i < 10; i++) begin
         press(8'h41 + 8'(i));
         finish_draw();
      end
      chk("full_num", 32'(letterNum), 10);
      chk("full_l9", 32'(l9), 32'h4A);
      chk("full_l4", 32'(l4), 32'h45);

      press(8'h4B);
      chk("over_num", 32'(letterNum), 10);
      chk("over_l9", 32'(l9), 32'h4A);
      chk("over_busy", 32'({draw_restart, busy}), 0);

      press(8'h08);
      chk("bs_num", 32'(letterNum), 9);
      chk("bs_l9", 32'(l9), 32'h20);
      chk("bs_restart", 32'(draw_restart), 1);
      finish_draw();

      press(8'h08);
      chk("bs2_num", 32'(letterNum), 8);
      press(8'h42);
      chk("pend_drop0", 32'(key_dropped), 0);
      press(8'h43);
      chk("pend_drop1", 32'(key_dropped), 1);
      chk("pend_num", 32'(letterNum), 8);
      finish_draw();
      @(negedge clock);
      chk("pend_l8", 32'(l8), 32'h42);
      chk("pend_num2", 32'(letterNum), 9);
      chk("pend_restart", 32'(draw_restart), 1);
      finish_draw();
      repeat (3) @(negedge clock);
      chk("pend_noC", 32'(letterNum), 9);
      chk("pend_l9", 32'(l9), 32'h20);
      chk("pend_idle", 32'(busy), 0);

      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("clr_num", 32'(letterNum), 0);
      chk("clr_flag", 32'(key_dropped), 0);
      finish_draw();
      press(8'h50);
      finish_draw();
      press(8'h51);
      finish_draw();
      press(8'h52);
      chk("c3_num", 32'(letterNum), 3);
      chk("c3_l2", 32'(l2), 32'h52);
      @(negedge clock);
      chk("c3_draw", 32'(draw_enable), 1);
      clear     = 1'b1;
      key_valid = 1'b1;
      key_code  = 8'h53;
      @(negedge clock);
      clear     = 1'b0;
      key_valid = 1'b0;
      chk("cd_num", 32'(letterNum), 0);
      chk("cd_slots", 32'({l0, l1, l2}), 32'h202020);
      chk("cd_restart", 32'({draw_restart, draw_enable}), 32'b10);
      finish_draw();
      repeat (2) @(negedge clock);
      chk("cd_keylost", 32'(letterNum), 0);
      chk("cd_idle", 32'(busy), 0);

      press(8'h08);
      chk("bs0_num", 32'(letterNum), 0);
      chk("bs0_busy", 32'(busy), 0);
      press(8'h0D);
      chk("en0_ready", 32'(word_ready), 0);
      chk("en0_busy", 32'(busy), 0);

      press(8'h7A);
      chk("z_l0", 32'(l0), 32'h5A);
      finish_draw();
      press(8'h0D);
      chk("en_ready", 32'(word_ready), 1);
      chk("en_nodraw", 32'({draw_restart, busy}), 0);
      press(8'h59);
      chk("lock_num", 32'(letterNum), 1);
      chk("lock_l1", 32'(l1), 32'h20);
      chk("lock_busy", 32'(busy), 0);

      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("unlock_ready", 32'(word_ready), 0);
      finish_draw();
      press(8'h4D);
      @(negedge clock);
      chk("r_draw", 32'(draw_enable), 1);
      chk("r_num", 32'(letterNum), 1);
      #2 reset = 1'b1;
      #1;
      chk("r_enable", 32'({draw_restart, draw_enable, busy}), 0);
      chk("r_num0", 32'(letterNum), 0);
      chk("r_l0", 32'(l0), 32'h20);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      chk("r_noredraw", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
